// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and types for the UART program loader.
// Start/stop marker words, word width and loader FSM states.
package prog_loader_pkg;

  localparam int WORD_W = 24;

  localparam logic [WORD_W-1:0] START_WORD    = 24'h0000FF;
  localparam logic [WORD_W-1:0] STOP_RST_WORD = 24'h00F0FF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RELEASE
  } state_e;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte stream in / imem write port out of the program loader.
// master = UART rx + imem side, slave = loader side.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 8
);
  import prog_loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/uart_prog_loader_word_assembler.sv
// Collects rx bytes into 24-bit words, MSB first.
// Optional LOADER_TIMEOUT_EN drops a stalled partial word.
module word_assembler
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              framed_i,
  input  logic              en_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic              take;
  logic              to_hit;

  assign take         = rx_valid_i & en_i;
  assign word_o       = {shift_q[WORD_W-9:0], rx_data_i};
  // Unframed: every byte is a sliding-window candidate.
  assign word_valid_o = take && (!framed_i || idx_q == 2'd2);

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q, to_d;

  assign to_hit = framed_i && idx_q != 2'd0 && !take && to_q == TO_LAST;

  // Count idle cycles while a partial word is pending.
  always_comb begin
    to_d = to_q + 1'b1;
    if (take || clr_i || !framed_i || idx_q == 2'd0 || to_hit)
      to_d = '0;
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  wire unused_timeout = |TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // Shift and byte index next state.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (take) begin
      shift_d = word_o;
      if (framed_i)
        idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    if (to_hit)
      idx_d = 2'd0;
    if (clr_i) begin
      shift_d = '0;
      idx_d   = 2'd0;
    end
  end

  // Shift register and byte index.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Downloads a program over UART into imem and resets the CPU.
// Build option: LOADER_TIMEOUT_EN (inter-byte timeout in LOAD).
module uart_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  uart_prog_loader_if.slave bus,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              loading,
  output logic [ADDR_W:0]   words_loaded,
  output logic              overflow
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              ovf_q, ovf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              clr;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  word_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr),
    .framed_i     (state_q == LOAD),
    .en_i         (state_q != RELEASE),
    .rx_data_i    (bus.rx_data),
    .rx_valid_i   (bus.rx_valid),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Loader FSM: word classification, imem writes, reset pulse.
  always_comb begin
    state_d = state_q;
    wl_d    = wl_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rcnt_d  = rcnt_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (word_valid && word == START_WORD) begin
          state_d = LOAD;
          wl_d    = '0;
          ovf_d   = 1'b0;
          clr     = 1'b1;
        end
      end
      LOAD: begin
        if (word_valid) begin
          if (word == STOP_RST_WORD) begin
            state_d = RELEASE;
            rcnt_d  = '0;
          end else if (word == START_WORD) begin
            wl_d  = '0;
            ovf_d = 1'b0;
          end else if (wl_q < DEPTH_C) begin
            we_d    = 1'b1;
            addr_d  = wl_q[ADDR_W-1:0];
            wdata_d = word;
            wl_d    = wl_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (rcnt_q == RC_LAST) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wl_q    <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wl_q    <= wl_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = state_q != IDLE;
  assign cpu_rst        = state_q == RELEASE;
  assign loading        = state_q == LOAD;
  assign words_loaded   = wl_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader: directed scenarios plus a
// randomized byte-stream run against a byte-level reference model.
module tb_uart_prog_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_W(8)) b0 ();
  uart_prog_loader_if #(.ADDR_W(8)) b1 ();

  logic       h0, r0, l0, o0, h1, r1, l1, o1;
  logic [8:0] wl0, wl1;

  uart_prog_loader #(
    .ADDR_W(8), .DEPTH(256), .RST_CYCLES(16), .TIMEOUT_CYCLES(50)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .cpu_hold(h0), .cpu_rst(r0), .loading(l0),
    .words_loaded(wl0), .overflow(o0)
  );

  uart_prog_loader #(
    .ADDR_W(8), .DEPTH(2), .RST_CYCLES(16), .TIMEOUT_CYCLES(50)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .cpu_hold(h1), .cpu_rst(r1), .loading(l1),
    .words_loaded(wl1), .overflow(o1)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wr0[$];
  logic [31:0] wr1[$];
  int          pl0[$];
  int          pl1[$];
  int          run0 = 0;
  int          run1 = 0;
  int          hv = 0;
  logic [7:0]  sq[$];

  logic [31:0] e_w[$];
  int          e_wl;
  logic        e_ov;
  int          e_rel;

  // Observe writes, reset pulse lengths and hold/reset consistency.
  always @(negedge clk) begin
    if (b0.imem_we) wr0.push_back({b0.imem_addr, b0.imem_wdata});
    if (b1.imem_we) wr1.push_back({b1.imem_addr, b1.imem_wdata});
    if (r0) run0++;
    else if (run0 != 0) begin pl0.push_back(run0); run0 = 0; end
    if (r1) run1++;
    else if (run1 != 0) begin pl1.push_back(run1); run1 = 0; end
    if (r0 && !h0) hv++;
    if (h0 && !r0 && !l0) hv++;
    if (r1 && !h1) hv++;
    if (h1 && !r1 && !l1) hv++;
  end

  // Byte-level model: sliding start match in idle, framed words in load.
  task automatic model(input int depth);
    logic [23:0] win;
    logic [23:0] w;
    int st, idx, addr;
    e_w.delete();
    e_wl = 0; e_ov = 0; e_rel = 0;
    win = 0; w = 0; st = 0; idx = 0; addr = 0;
    foreach (sq[i]) begin
      if (st == 0) begin
        win = {win[15:0], sq[i]};
        if (win == 24'h0000FF) begin
          st = 1; idx = 0; addr = 0; e_wl = 0; e_ov = 0;
        end
      end else begin
        w = {w[15:0], sq[i]};
        idx++;
        if (idx == 3) begin
          idx = 0;
          if (w == 24'h00F0FF) begin
            st = 0; win = 0; e_rel++;
          end else if (w == 24'h0000FF) begin
            addr = 0; e_wl = 0; e_ov = 0;
          end else if (addr < depth) begin
            e_w.push_back({addr[7:0], w});
            addr++;
            e_wl = addr;
          end else begin
            e_ov = 1;
          end
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    b0.rx_data = b; b1.rx_data = b;
    b0.rx_valid = 1'b1; b1.rx_valid = 1'b1;
    @(negedge clk);
    b0.rx_valid = 1'b0; b1.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_q(input int gmax);
    foreach (sq[i]) begin
      send(sq[i]);
      if (gmax > 0) idle(int'($urandom_range(gmax, 0)));
    end
  endtask

  task automatic mon_clr();
    wr0.delete(); wr1.delete(); pl0.delete(); pl1.delete(); hv = 0;
  endtask

  task automatic test_reset();
    idle(3);
    n_chk++;
    if ({h0, r0, l0, o0, wl0, b0.imem_we, b0.imem_addr, b0.imem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_dut0: got %h want 0",
        {h0, r0, l0, o0, wl0, b0.imem_we, b0.imem_addr, b0.imem_wdata});
    end
    n_chk++;
    if ({h1, r1, l1, o1, wl1, b1.imem_we, b1.imem_addr, b1.imem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: got %h want 0",
        {h1, r1, l1, o1, wl1, b1.imem_we, b1.imem_addr, b1.imem_wdata});
    end
    rst = 1'b0;
    idle(3);
    n_chk++;
    if ({h0, r0, l0, b0.imem_we} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 0", {h0, r0, l0, b0.imem_we});
    end
  endtask

  task automatic test_basic();
    mon_clr();
    sq = '{8'h00, 8'h00, 8'hFF};
    send_q(0);
    n_chk++;
    if ({h0, l0} !== 2'b11) begin
      n_fail++; $display("FAIL basic_hold_at_start: got %b want 11", {h0, l0});
    end
    sq = '{8'h80, 8'h01, 8'h0A, 8'h80, 8'h02, 8'h14, 8'h00, 8'hF0, 8'hFF};
    send_q(2);
    idle(40);
    n_chk++;
    if (wr0.size() != 2) begin
      n_fail++; $display("FAIL basic_nwrites: got %0d want 2", wr0.size());
    end
    n_chk++;
    if (wr0.size() < 2 || wr0[0] !== 32'h0080010A || wr0[1] !== 32'h01800214) begin
      n_fail++; $display("FAIL basic_writes: got %p want 0080010a 01800214", wr0);
    end
    n_chk++;
    if (wl0 !== 9'd2) begin
      n_fail++; $display("FAIL basic_words_loaded: got %0d want 2", wl0);
    end
    n_chk++;
    if (pl0.size() != 1 || pl0[0] != 16) begin
      n_fail++; $display("FAIL basic_rst_pulse: got %p want 16", pl0);
    end
    n_chk++;
    if (hv != 0 || h0 !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: got viol=%0d hold=%b want 0 0", hv, h0);
    end
    n_chk++;
    if ({b0.imem_addr, b0.imem_wdata} !== 32'h01800214) begin
      n_fail++; $display("FAIL basic_addr_hold: got %h want 01800214",
        {b0.imem_addr, b0.imem_wdata});
    end
  endtask

  task automatic test_resync();
    mon_clr();
    sq = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'hFF, 8'h03, 8'h13, 8'h00,
           8'h00, 8'hF0, 8'hFF};
    send_q(1);
    idle(40);
    n_chk++;
    if (wr0.size() != 1 || wr0[0] !== 32'h00031300) begin
      n_fail++; $display("FAIL resync_write: got %p want 00031300", wr0);
    end
    n_chk++;
    if (pl0.size() != 1 || hv != 0) begin
      n_fail++; $display("FAIL resync_release: got pulses=%0d viol=%0d want 1 0",
        pl0.size(), hv);
    end
  endtask

  task automatic test_overflow();
    mon_clr();
    sq = '{8'h00, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
           8'h77, 8'h88, 8'h99, 8'h00, 8'hF0, 8'hFF};
    send_q(0);
    idle(40);
    n_chk++;
    if (wr1.size() != 2 || wr1[0] !== 32'h00112233 || wr1[1] !== 32'h01445566) begin
      n_fail++; $display("FAIL ovf_writes: got %p want 00112233 01445566", wr1);
    end
    n_chk++;
    if ({o1, wl1} !== {1'b1, 9'd2}) begin
      n_fail++; $display("FAIL ovf_flag: got ovf=%b wl=%0d want 1 2", o1, wl1);
    end
    n_chk++;
    if (pl1.size() != 1 || pl1[0] != 16) begin
      n_fail++; $display("FAIL ovf_release: got %p want 16", pl1);
    end
    n_chk++;
    if ({o0, wl0} !== {1'b0, 9'd3}) begin
      n_fail++; $display("FAIL ovf_deep: got ovf=%b wl=%0d want 0 3", o0, wl0);
    end
  endtask

  task automatic test_restart();
    mon_clr();
    sq = '{8'h00, 8'h00, 8'hFF, 8'hD4, 8'h00, 8'hFD, 8'h00, 8'h00, 8'hFF,
           8'h80, 8'h06, 8'h32, 8'h00, 8'hF0, 8'hFF};
    send_q(1);
    idle(40);
    n_chk++;
    if (wr0.size() != 2 || wr0[0] !== 32'h00D400FD || wr0[1] !== 32'h00800632) begin
      n_fail++; $display("FAIL restart_writes: got %p want 00d400fd 00800632", wr0);
    end
    n_chk++;
    if (wl0 !== 9'd1) begin
      n_fail++; $display("FAIL restart_words_loaded: got %0d want 1", wl0);
    end
  endtask

  task automatic test_random();
    logic [23:0] w;
    for (int it = 0; it < 10; it++) begin
      mon_clr();
      sq.delete();
      for (int g = 0; g < int'($urandom_range(3, 0)); g++)
        sq.push_back(8'($urandom_range(254, 1)));
      sq.push_back(8'h00); sq.push_back(8'h00); sq.push_back(8'hFF);
      for (int k = 0; k < int'($urandom_range(4, 0)); k++) begin
        do w = 24'($urandom); while (w == 24'h0000FF || w == 24'h00F0FF);
        sq.push_back(w[23:16]); sq.push_back(w[15:8]); sq.push_back(w[7:0]);
      end
      sq.push_back(8'h00); sq.push_back(8'hF0); sq.push_back(8'hFF);
      send_q(3);
      idle(40);
      model(256);
      n_chk++;
      if (wr0.size() != e_w.size() || wl0 !== 9'(e_wl) || o0 !== e_ov) begin
        n_fail++; $display("FAIL rand_dut0_summary: got n=%0d wl=%0d ovf=%b want %0d %0d %b",
          wr0.size(), wl0, o0, e_w.size(), e_wl, e_ov);
      end
      foreach (e_w[i]) begin
        n_chk++;
        if (i >= wr0.size() || wr0[i] !== e_w[i]) begin
          n_fail++; $display("FAIL rand_dut0_write: got %p want %h", wr0, e_w[i]);
        end
      end
      n_chk++;
      if (pl0.size() != e_rel || hv != 0) begin
        n_fail++; $display("FAIL rand_release: got pulses=%0d viol=%0d want %0d 0",
          pl0.size(), hv, e_rel);
      end
      model(2);
      n_chk++;
      if (wr1.size() != e_w.size() || wl1 !== 9'(e_wl) || o1 !== e_ov) begin
        n_fail++; $display("FAIL rand_dut1_summary: got n=%0d wl=%0d ovf=%b want %0d %0d %b",
          wr1.size(), wl1, o1, e_w.size(), e_wl, e_ov);
      end
      foreach (e_w[i]) begin
        n_chk++;
        if (i >= wr1.size() || wr1[i] !== e_w[i]) begin
          n_fail++; $display("FAIL rand_dut1_write: got %p want %h", wr1, e_w[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    mon_clr();
    sq = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h01};
    send_q(0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_chk++;
    if ({h0, r0, l0, o0, wl0, b0.imem_we, b0.imem_addr, b0.imem_wdata} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h want 0",
        {h0, r0, l0, o0, wl0, b0.imem_we, b0.imem_addr, b0.imem_wdata});
    end
    sq = '{8'h00, 8'hF0, 8'hFF};
    send_q(0);
    idle(30);
    n_chk++;
    if (wr0.size() != 0 || pl0.size() != 0 || h0 !== 1'b0) begin
      n_fail++; $display("FAIL midrst_stop_ignored: got writes=%0d pulses=%0d hold=%b want 0 0 0",
        wr0.size(), pl0.size(), h0);
    end
  endtask

  task automatic test_timeout();
    mon_clr();
    sq = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h01};
    send_q(0);
    idle(60);
    sq = '{8'h80, 8'h02, 8'h14};
    send_q(0);
    idle(5);
    n_chk++;
`ifdef LOADER_TIMEOUT_EN
    if (wr0.size() != 1 || wr0[0] !== 32'h00800214) begin
      n_fail++; $display("FAIL timeout_write: got %p want 00800214", wr0);
    end
`else
    if (wr0.size() != 1 || wr0[0] !== 32'h00800180) begin
      n_fail++; $display("FAIL no_timeout_write: got %p want 00800180", wr0);
    end
`endif
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    b0.rx_data = 8'h00; b0.rx_valid = 1'b0;
    b1.rx_data = 8'h00; b1.rx_valid = 1'b0;
    test_reset();
    test_basic();
    test_resync();
    test_overflow();
    test_restart();
    test_random();
    test_reset_mid_load();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sequences program download from the UART receiver into instruction memory and gates the CPU around the download.
- Assembles received bytes into 24-bit instruction words.
- Detects the start word 0x0000FF and the stop-with-reset word 0x00F0FF.
- Writes each word to sequential imem addresses, holds the CPU while loading, then issues a CPU reset pulse. Sits between the UART rx block and the imem write port / CPU reset in full_cpu.

Parameters:
ADDR_W, 8, imem address width
DEPTH, 256, number of writable imem words (≤ 2^ADDR_W)
RST_CYCLES, 16, length of cpu_rst pulse after stop word (≥1)
TIMEOUT_CYCLES, 100000, inter-byte timeout (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte, valid with rx_valid
rx_valid  in  1  single-cycle strobe per received byte
imem_we  out  1  imem write enable, one-cycle pulse
imem_addr  out  ADDR_W  imem write address
imem_wdata  out  24  instruction word {byte0,byte1,byte2}
cpu_hold  out  1  CPU stall/hold while loading
cpu_rst  out  1  CPU reset pulse after load
loading  out  1  high in LOAD state
words_loaded  out  ADDR_W+1  words written in current/last load
overflow  out  1  sticky: word arrived with addr ≥ DEPTH

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: every output is 0; state is IDLE; byte index is 0; shift register is 0.
- Byte order: first received byte is the MSB. word = {b0,b1,b2}.
- IDLE:
  - Each rx_valid shifts rx_data into a 24-bit sliding register.
  - When the register (including the new byte) equals 0x0000FF: go to LOAD, addr=0, words_loaded=0, overflow cleared, byte index=0, cpu_hold=1 from the next cycle.
  - Other bytes are discarded. No imem writes occur.
- LOAD:
  - Bytes are collected at index 0,1,2.
  - On the third byte, the word is classified:
    - 0x00F0FF → RELEASE. No write.
    - 0x0000FF → restart: addr=0, words_loaded=0, overflow cleared. No write.
    - Otherwise, if addr < DEPTH: imem_we=1 for exactly one cycle, in the cycle after the third rx_valid, with imem_addr=addr and imem_wdata=word. Then addr++ and words_loaded++.
    - Otherwise (addr ≥ DEPTH): no write; overflow=1 (sticky until the next start word or rst); remain in LOAD.
- RELEASE:
  - cpu_rst=1 for exactly RST_CYCLES cycles, starting the cycle after the stop word's third rx_valid.
  - cpu_hold stays 1 throughout and drops in the same cycle cpu_rst drops. Then go to IDLE.
  - rx_valid during RELEASE is ignored; the sliding register is cleared on entry to IDLE.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- words_loaded holds after release until the next start word.
- Simultaneous events:
  - rst has priority over everything.
  - rst in LOAD or RELEASE returns to IDLE immediately, with cpu_hold and cpu_rst deasserted the next cycle and no partial write.
- Start word only matches on word boundaries in LOAD; in IDLE it matches at any byte alignment.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: in LOAD, a counter runs while the byte index ≠ 0. If TIMEOUT_CYCLES elapse without rx_valid, the partial word is discarded and the byte index returns to 0. State stays LOAD and addr is unchanged.
- Not defined: no counter; a partial word waits indefinitely.

Decomposition:
- Package prog_loader_pkg:
  - START_WORD=24'h0000FF and STOP_RST_WORD=24'h00F0FF.
  - WORD_W=24.
  - State enum {IDLE, LOAD, RELEASE}.
- One sub-module: word_assembler. It holds the byte index, the shift register, the word_valid strobe and the optional timeout.
- The FSM, address counter and reset pulse counter stay in the top.

Test Plan:
- Basic load: rx 00 00 FF, 80 01 0A, 80 02 14, 00 F0 FF → imem writes addr0=0x80010A, addr1=0x800214. words_loaded=2. cpu_hold high from the start word through the end of cpu_rst. cpu_rst high exactly 16 cycles, then IDLE with hold=0.
- Resync: rx AA 55 00 00 FF 03 13 00 00 F0 FF → garbage ignored, single write addr0=0x031300, release.
- Overflow: DEPTH=2, send start, 3 data words, stop → writes at addr0 and addr1 only. overflow=1. Release still occurs.
- Restart: start, D4 00 FD, start, 80 06 32, stop → addr0 rewritten last with 0x800632. words_loaded=1.
- Reset mid-load: start, 80 01, assert rst 1 cycle, then stop word → no imem_we, no cpu_rst. All outputs 0 after rst. Stop word is ignored in IDLE.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=50: start, 80 01, idle 60 cycles, then 80 02 14 → addr0=0x800214. No write of a mixed word.
